// File: rtl/slon5_pkg.sv
// Shared slon5 definitions: FIFO geometry, the FIFO status record and the
// helper that sizes occupancy counters.
package slon5_pkg;

    localparam int FIFO_DATA_W = 16;
    localparam int FIFO_DEPTH  = 1024;

    // Bits needed to hold every value in 0..n inclusive.
    function automatic int bits(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int FIFO_COUNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                    full;
        logic                    empty;
        logic [FIFO_COUNT_W-1:0] count;
        logic                    overflow;
        logic                    underflow;
        logic                    valid;
    } fifo_16_t;

endpackage

// File: rtl/slon_fifo_m_if.sv
// Push/pop bundle between the slon5 source/destination FSMs (master) and the
// FIFO storage (slave).
interface slon_fifo_m_if
    import slon5_pkg::*;
#(
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int COUNT_W = FIFO_COUNT_W
);
    logic [DATA_W-1:0]  din;
    logic               wr_en;
    logic               rd_en;
    logic [DATA_W-1:0]  dout;
    logic               valid;
    logic               full;
    logic               empty;
    logic [COUNT_W-1:0] data_count;
    logic               overflow;
    logic               underflow;

    modport master (
        output din, wr_en, rd_en,
        input  dout, valid, full, empty, data_count, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, valid, full, empty, data_count, overflow, underflow
    );
endinterface

// File: rtl/slon_fifo_m_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// No reset on the array or read register so it maps onto block RAM.
module sdp_ram_m #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
        if (re) begin
            dout_reg <= mem[raddr];
        end
    end

    assign dout = dout_reg;
endmodule

// File: rtl/slon_fifo_m.sv
// Single-clock standard-read FIFO for the slon5 push/pop path: pointers,
// occupancy, registered flags and status pulses around an inferred RAM.
module slon_fifo_m
    import slon5_pkg::*;
#(
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int COUNT_W = bits(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    slon_fifo_m_if.slave  fifo
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    logic [ADDR_W-1:0]  wr_ptr_reg;
    logic [ADDR_W-1:0]  rd_ptr_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;
    logic               full_reg;
    logic               empty_reg;
    logic               valid_reg;
    logic               overflow_reg;
    logic               underflow_reg;
    logic               dout_clear_reg;
    logic               wr_acc;
    logic               rd_acc;
    logic [DATA_W-1:0]  ram_dout;

    always_comb begin
        wr_acc     = fifo.wr_en & ~full_reg;
        rd_acc     = fifo.rd_en & ~empty_reg;
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + COUNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - COUNT_W'(1);
        end
    end

    // Flags track count_next so they move in the same cycle as data_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            empty_reg      <= 1'b1;
            valid_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            dout_clear_reg <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg     <= rd_ptr_reg + ADDR_W'(1);
                dout_clear_reg <= 1'b0;
            end
            count_reg     <= count_next;
            full_reg      <= (count_next == FULL_COUNT);
            empty_reg     <= (count_next == '0);
            valid_reg     <= rd_acc;
            overflow_reg  <= fifo.wr_en & full_reg;
            underflow_reg <= fifo.rd_en & empty_reg;
        end
    end

    sdp_ram_m #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_reg),
        .din   (fifo.din),
        .re    (rd_acc),
        .raddr (rd_ptr_reg),
        .dout  (ram_dout)
    );

    // The RAM read register carries no reset, so dout is forced to zero from
    // reset until the first accepted read refreshes it.
    assign fifo.dout       = dout_clear_reg ? '0 : ram_dout;
    assign fifo.valid      = valid_reg;
    assign fifo.full       = full_reg;
    assign fifo.empty      = empty_reg;
    assign fifo.data_count = count_reg;
    assign fifo.overflow   = overflow_reg;
    assign fifo.underflow  = underflow_reg;
endmodule
